// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1/8N2 serial transmitter with a fractional baud accumulator.
// Bytes are queued into a 2^FIFO_AW deep FIFO at full clock rate and sent LSB first.
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset, dominates every other input
//   wr_en      write strobe, one byte per asserted cycle
//   wr_data    byte to enqueue
//   full       FIFO holds 2^FIFO_AW entries
//   fifo_count current FIFO occupancy
//   overflow   one-cycle pulse when a write arrives while full (byte dropped)
//   tx_busy    transmitter active or FIFO non-empty
//   txd        registered serial line, idle high
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ  = 15000000,
    parameter int unsigned BAUD      = 38400,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned FIFO_AW   = 4,
    parameter int unsigned STOP_BITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    output logic               tx_busy,
    output logic               txd
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned INC   = ((BAUD << (ACC_WIDTH - 4)) + (CLK_FREQ >> 5)) / (CLK_FREQ >> 4);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH:0]   acc_q, acc_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic [7:0]           mem_q [DEPTH];
    logic [7:0]           mem_d [DEPTH];
    logic [7:0]           sr_q, sr_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 txd_q, txd_d;
    logic                 full_q, full_d;
    logic                 overflow_q, overflow_d;
    logic                 busy_q, busy_d;

    logic tick;
    logic push;
    logic pop;

    // Next-state, FIFO bookkeeping and registered-output computation.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_d      = mem_q;
        sr_d       = sr_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;

        tick = acc_q[ACC_WIDTH];
        // full_q is the occupancy at the start of the cycle, so a same-cycle pop never frees room.
        push = wr_en && !full_q;
        pop  = (state_q == S_IDLE) && (count_q != '0);

        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    sr_d    = mem_q[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d    = S_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accumulator runs whenever the next state is active, so the first bit of a frame
        // gets a full tick interval measured from the START state.
        if (state_d == S_IDLE) begin
            acc_d = '0;
        end else begin
            acc_d = {1'b0, acc_q[ACC_WIDTH-1:0]} + (ACC_WIDTH+1)'(INC);
        end

        case (state_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = sr_q[bit_idx_q];
            default: txd_d = 1'b1;
        endcase

        full_d     = (count_d == (FIFO_AW+1)'(DEPTH));
        overflow_d = wr_en && full_q;
        busy_d     = (state_d != S_IDLE) || (count_d != '0);
    end

    // FIFO storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sr_q       <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sr_q       <= sr_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            txd_q      <= txd_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign full       = full_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign tx_busy    = busy_q;
    assign txd        = txd_q;

endmodule
